// File: rtl/s2_sched_pkg.sv
`default_nettype none
// ============================================================================
// s2_sched_pkg : shared types and helpers for the S2 round-robin scheduler
// Rev 1.0
// ============================================================================
package s2_sched_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic a1;
    logic b1;
    logic a0;
    logic b0;
  } sel_pins_t;

  // The external S2 cell takes each select bit on a paired A/B input.
  function automatic sel_pins_t sel_to_pins(input logic [1:0] sel);
    sel_pins_t p;
    p.a1 = sel[1];
    p.b1 = sel[1];
    p.a0 = sel[0];
    p.b0 = sel[0];
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// rr_pick4 : combinational 4-way round-robin picker starting at ptr
// Rev 1.0
// ============================================================================
module rr_pick4
  import s2_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               any,
  output logic [1:0]         idx
);

  logic [1:0] cand;

  // Walk from the farthest offset down so the nearest-to-ptr hit wins.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/s2_rr_scheduler.sv
`default_nettype none
// ============================================================================
// s2_rr_scheduler : burst round-robin over four requesters, registered 4:1 select
// Rev 1.0
// ============================================================================
module s2_rr_scheduler
  import s2_sched_pkg::*;
#(
  parameter int N         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_REQ-1:0] req,
  input  logic [N-1:0]       d0,
  input  logic [N-1:0]       d1,
  input  logic [N-1:0]       d2,
  input  logic [N-1:0]       d3,
  output logic [NUM_REQ-1:0] gnt,
  output logic [N-1:0]       out,
  output logic               out_vld,
  output logic [1:0]         out_src,
  output logic               a1,
  output logic               b1,
  output logic               a0,
  output logic               b0
);

  localparam int            CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N-1:0]       out_q, out_d;
  logic               vld_q, vld_d;
  logic [1:0]         src_q, src_d;
  sel_pins_t          pins_q, pins_d;

  logic               pick_any;
  logic [1:0]         pick_idx;
  logic [1:0]         arb_ptr;
  logic [N-1:0]       d_sel;
  logic               burst_end;

  // While busy, arbitration only matters at burst end, where the search starts after the owner.
  assign arb_ptr = (state_q == BUSY) ? idx_q + 2'd1 : ptr_q;

  rr_pick4 u_pick (
    .req (req),
    .ptr (arb_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    case (idx_q)
      2'd0:    d_sel = d0;
      2'd1:    d_sel = d1;
      2'd2:    d_sel = d2;
      default: d_sel = d3;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    src_d     = src_q;
    vld_d     = 1'b0;
    pins_d    = pins_q;
    burst_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          gnt_d   = 4'b0001 << pick_idx;
          idx_d   = pick_idx;
          pins_d  = sel_to_pins(pick_idx);
        end
      end
      BUSY: begin
        if (req[idx_q]) begin
          out_d = d_sel;
          src_d = idx_q;
          vld_d = 1'b1;
          if (cnt_q == LAST_BEAT) burst_end = 1'b1;
          else                    cnt_d     = cnt_q + 1'b1;
        end else begin
          burst_end = 1'b1;
        end

        if (burst_end) begin
          ptr_d = idx_q + 2'd1;
          cnt_d = '0;
          if (pick_any) begin
            gnt_d  = 4'b0001 << pick_idx;
            idx_d  = pick_idx;
            pins_d = sel_to_pins(pick_idx);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            pins_d  = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        pins_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      src_q   <= '0;
      pins_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      src_q   <= src_d;
      pins_q  <= pins_d;
    end
  end

  assign gnt     = gnt_q;
  assign out     = out_q;
  assign out_vld = vld_q;
  assign out_src = src_q;
  assign a1      = pins_q.a1;
  assign b1      = pins_q.b1;
  assign a0      = pins_q.a0;
  assign b0      = pins_q.b0;

endmodule
`default_nettype wire

// File: tb/tb_s2_rr_scheduler.sv
`default_nettype none
// ============================================================================
// tb_s2_rr_scheduler : scoreboard bench, MAX_BURST=4 (inst A) and MAX_BURST=1 (inst B)
// Rev 1.0
// ============================================================================
module tb_s2_rr_scheduler;

  logic       clk = 1'b0;
  logic       clr_a, clr_b;
  logic [3:0] req_a, req_b;
  logic [7:0] da[4];
  logic [7:0] db[4];

  logic [3:0] gnt_a, gnt_b;
  logic [7:0] out_a, out_b;
  logic       vld_a, vld_b;
  logic [1:0] src_a, src_b;
  logic       a1_a, b1_a, a0_a, b0_a;
  logic       a1_b, b1_b, a0_b, b0_b;

  always #5 clk = ~clk;

  s2_rr_scheduler #(.N(8), .MAX_BURST(4)) dut_a (
    .clk(clk), .clr(clr_a), .req(req_a),
    .d0(da[0]), .d1(da[1]), .d2(da[2]), .d3(da[3]),
    .gnt(gnt_a), .out(out_a), .out_vld(vld_a), .out_src(src_a),
    .a1(a1_a), .b1(b1_a), .a0(a0_a), .b0(b0_a)
  );

  s2_rr_scheduler #(.N(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .clr(clr_b), .req(req_b),
    .d0(db[0]), .d1(db[1]), .d2(db[2]), .d3(db[3]),
    .gnt(gnt_b), .out(out_b), .out_vld(vld_b), .out_src(src_b),
    .a1(a1_b), .b1(b1_b), .a0(a0_b), .b0(b0_b)
  );

  // Reference model: who owns the path, whose turn is next, beats taken so far.
  int         owner[2] = '{-1, -1};
  int         turn[2]  = '{0, 0};
  int         taken[2] = '{0, 0};
  bit         m_vld[2] = '{1'b0, 1'b0};
  logic [7:0] m_out[2] = '{8'h00, 8'h00};
  logic [1:0] m_src[2] = '{2'd0, 2'd0};
  logic [9:0] sb_a[$];
  logic [9:0] sb_b[$];

  int  n_cmp = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_step(input int m, input int mb, input logic c, input logic [3:0] r,
                            input logic [7:0] x0, input logic [7:0] x1,
                            input logic [7:0] x2, input logic [7:0] x3);
    logic [7:0] dv[4];
    bit done;
    int i;
    dv[0] = x0; dv[1] = x1; dv[2] = x2; dv[3] = x3;
    if (c) begin
      owner[m] = -1; turn[m] = 0; taken[m] = 0; m_vld[m] = 1'b0;
      m_out[m] = 8'h00; m_src[m] = 2'd0;
      if (m == 0) sb_a.delete(); else sb_b.delete();
    end else if (owner[m] < 0) begin
      m_vld[m] = 1'b0;
      owner[m] = pick(r, turn[m]);
    end else begin
      i = owner[m];
      done = 1'b0;
      if (r[i]) begin
        m_vld[m] = 1'b1;
        m_out[m] = dv[i];
        m_src[m] = 2'(i);
        if (m == 0) sb_a.push_back({2'(i), dv[i]}); else sb_b.push_back({2'(i), dv[i]});
        taken[m]++;
        if (taken[m] == mb) done = 1'b1;
      end else begin
        m_vld[m] = 1'b0;
        done = 1'b1;
      end
      if (done) begin
        turn[m]  = (i + 1) % 4;
        taken[m] = 0;
        owner[m] = pick(r, turn[m]);
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 4, clr_a, req_a, da[0], da[1], da[2], da[3]);
    model_step(1, 1, clr_b, req_b, db[0], db[1], db[2], db[3]);
  end

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[inst %0d] t=%0t: got %0h expected %0h", name, m, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_gnt(input int o);
    return (o < 0) ? 4'b0000 : (4'b0001 << o);
  endfunction

  function automatic logic [3:0] exp_pins(input int o);
    logic [1:0] s;
    if (o < 0) return 4'b0000;
    s = 2'(o);
    return {s[1], s[1], s[0], s[0]};
  endfunction

  task automatic monitor_one(input int m, input logic [3:0] g, input logic [7:0] o,
                             input logic v, input logic [1:0] s, input logic [3:0] pins);
    logic [9:0] e;
    chk("gnt", m, 32'(g), 32'(exp_gnt(owner[m])));
    chk("sel_pins", m, 32'(pins), 32'(exp_pins(owner[m])));
    chk("out_vld", m, 32'(v), 32'(m_vld[m]));
    if (v === 1'b1) begin
      if ((m == 0 && sb_a.size() == 0) || (m == 1 && sb_b.size() == 0)) begin
        chk("beat_expected", m, 32'(1), 32'(0));
      end else begin
        e = (m == 0) ? sb_a.pop_front() : sb_b.pop_front();
        chk("beat_data", m, 32'({s, o}), 32'(e));
      end
    end else begin
      chk("out_hold", m, 32'(o), 32'(m_out[m]));
      chk("src_hold", m, 32'(s), 32'(m_src[m]));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      monitor_one(0, gnt_a, out_a, vld_a, src_a, {a1_a, b1_a, a0_a, b0_a});
      monitor_one(1, gnt_b, out_b, vld_b, src_b, {a1_b, b1_b, a0_b, b0_b});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr_a();
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
  endtask

  initial begin
    clr_a = 1'b1; clr_b = 1'b1;
    req_a = 4'hF; req_b = 4'h0;
    for (int k = 0; k < 4; k++) begin
      da[k] = 8'h00; db[k] = 8'(8'h10 * (k + 1));
    end

    // Reset held two cycles with all requesting.
    tick(1);
    mon_en = 1'b1;
    tick(1);
    clr_a = 1'b0; clr_b = 1'b0;
    req_b = 4'b1010;
    tick(3);

    // Sole requester 2 across burst boundaries.
    pulse_clr_a();
    req_a = 4'b0100; da[2] = 8'hA5;
    tick(12);

    // All busy, distinct data.
    pulse_clr_a();
    da[0] = 8'h11; da[1] = 8'h22; da[2] = 8'h33; da[3] = 8'h44;
    req_a = 4'hF;
    tick(20);

    // Early release of requester 0 after two beats, requester 3 waiting.
    pulse_clr_a();
    req_a = 4'b1001;
    tick(3);
    req_a = 4'b1000;
    tick(6);

    // clr in the middle of a burst of requester 1.
    pulse_clr_a();
    req_a = 4'b0010;
    tick(2);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    req_a = 4'b0011;
    tick(6);

    // Randomized traffic on both instances.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3, 0) == 0) req_a = 4'($urandom_range(15, 0));
      if ($urandom_range(3, 0) == 0) req_b = 4'($urandom_range(15, 0));
      for (int k = 0; k < 4; k++) begin
        da[k] = 8'($urandom);
        db[k] = 8'($urandom);
      end
      clr_a = ($urandom_range(49, 0) == 0);
      clr_b = ($urandom_range(49, 0) == 0);
      tick(1);
    end
    clr_a = 1'b0; clr_b = 1'b0;
    req_a = 4'h0; req_b = 4'h0;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
